ps2_key_matrix: RTL and testbench



---
 rtl/ps2_key_matrix_if.sv | 25 ++
 rtl/ps2_key_matrix.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_matrix.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_matrix_if.sv
// Keyboard-side bundle for ps2_key_matrix: raw PS/2 lines, CPU column select,
// row readback and the keyboard-initiated reset pulse.
interface ps2_key_matrix_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] col;
    logic [6:0] row;
    logic       reset_out;

    modport master (
        output ps2_clk,
        output ps2_data,
        output col,
        input  row,
        input  reset_out
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        input  col,
        output row,
        output reset_out
    );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 receiver, make/break decoder and 5x7 key matrix with an F12-triggered reset pulse.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity or a missing stop bit.
module ps2_key_matrix #(
    parameter int TIMEOUT_CYCLES = 6000,
    parameter int RESET_CYCLES   = 6000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_key_matrix_if.slave  bus
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, next_state;
    logic [1:0]      clk_sync, data_sync;
    logic            clk_prev;
    logic            fall, data_bit, timeout;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg, code;
    logic [TO_W-1:0] to_cnt;
    logic            byte_valid;
    logic            start_frame, shift_en, frame_done, frame_ok;
    logic            brk, ext;
    logic [19:0]     matrix;
    logic            key_hit;
    logic [4:0]      key_idx;
    logic            f12_hit;
    logic [6:0]      row_v;

    // Not reset: the top feeds reset_out back into reset, so these rely on their power-up value.
    logic             f12_make = 1'b0;
    logic [RST_W-1:0] rst_cnt  = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[1];
    assign data_bit = data_sync[1];
    assign timeout  = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_bit) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        start_frame = 1'b0;
        shift_en    = 1'b0;
        frame_done  = 1'b0;
        if (fall && !timeout) begin
            start_frame = (state == IDLE) && !data_bit;
            shift_en    = (state == DATA);
            frame_done  = (state == STOP);
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    parity_bit <= 1'b0;
        else if (state == PARITY && fall && !timeout) parity_bit <= data_bit;
    end

    // Odd weight over data+parity, and the stop bit sampled at this edge must be high.
    assign frame_ok = (^{shift_reg, parity_bit}) & data_bit;
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt     <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            code       <= '0;
            byte_valid <= 1'b0;
        end else begin
            to_cnt     <= (state == IDLE || fall || timeout) ? '0 : to_cnt + TO_W'(1);
            if (start_frame)   bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)      shift_reg <= {data_bit, shift_reg[7:1]};
            if (frame_done)    code <= shift_reg;
            byte_valid <= frame_done & frame_ok;
        end
    end

    always_comb begin
        key_hit = 1'b1;
        key_idx = 5'd0;
        if (ext) begin
            key_hit = (code == 8'h5A);
            key_idx = 5'd17;
        end else begin
            case (code)
                8'h45: key_idx = 5'd0;
                8'h16: key_idx = 5'd1;
                8'h1E: key_idx = 5'd2;
                8'h26: key_idx = 5'd3;
                8'h25: key_idx = 5'd4;
                8'h2E: key_idx = 5'd5;
                8'h36: key_idx = 5'd6;
                8'h3D: key_idx = 5'd7;
                8'h3E: key_idx = 5'd8;
                8'h46: key_idx = 5'd9;
                8'h1C: key_idx = 5'd10;
                8'h32: key_idx = 5'd11;
                8'h21: key_idx = 5'd12;
                8'h23: key_idx = 5'd13;
                8'h24: key_idx = 5'd14;
                8'h2B: key_idx = 5'd15;
                8'h76: key_idx = 5'd16;
                8'h5A: key_idx = 5'd17;
                8'h66: key_idx = 5'd18;
                8'h29: key_idx = 5'd19;
                default: key_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk    <= 1'b0;
            ext    <= 1'b0;
            matrix <= '0;
        end else if (byte_valid) begin
            if (code == 8'hF0) begin
                brk <= 1'b1;
            end else if (code == 8'hE0) begin
                ext <= 1'b1;
            end else begin
                if (key_hit) matrix[key_idx] <= ~brk;
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    assign f12_hit = byte_valid && (code == 8'h07) && !brk && !ext;

    always_ff @(posedge clk) begin
        f12_make <= f12_hit;
        if (f12_make)            rst_cnt <= RST_W'(RESET_CYCLES);
        else if (rst_cnt != '0)  rst_cnt <= rst_cnt - RST_W'(1);
    end

    // Matrix index n sits at column n mod 5, row n div 5; rows 4-6 stay empty.
    always_comb begin
        row_v = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                row_v[r] = row_v[r] | (matrix[r*5 + c] & bus.col[c]);
            end
        end
    end

    assign bus.row       = row_v;
    assign bus.reset_out = (rst_cnt != '0);

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Randomised frame-level bench for ps2_key_matrix against a set-of-pressed-keys model.
module tb_ps2_key_matrix;

    localparam int HALF    = 8;
    localparam int TIMEOUT = 6000;
    localparam int RSTLEN  = 6000;

    logic clk = 1'b0;
    logic tb_rst;
    logic dut_reset;

    ps2_key_matrix_if bus();

    assign dut_reset = tb_rst | bus.reset_out;

    ps2_key_matrix #(.TIMEOUT_CYCLES(TIMEOUT), .RESET_CYCLES(RSTLEN)) dut (
        .clk   (clk),
        .reset (dut_reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int hi_cnt       = 0;

    always @(posedge clk) if (bus.reset_out === 1'b1) hi_cnt++;

    // Reference model: which of the 20 keys are down, plus the two prefix flags.
    bit         pressed [20];
    bit         m_brk, m_ext;
    logic [7:0] key_codes [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                   8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h76, 8'h5A, 8'h66, 8'h29};
    logic [7:0] pool [30] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                              8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h76, 8'h5A, 8'h66, 8'h29,
                              8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h75, 8'h00, 8'hAA, 8'hFF, 8'h12};

    function automatic int lookup(input logic [7:0] b, input bit ext);
        if (ext) return (b == 8'h5A) ? 17 : -1;
        for (int i = 0; i < 20; i++) if (key_codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            idx = lookup(b, m_ext);
            if (idx >= 0) pressed[idx] = !m_brk;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 20; i++) pressed[i] = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    function automatic logic [6:0] expected_row(input logic [4:0] c_sel);
        logic [6:0] r_out;
        r_out = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (r*5 + c < 20 && pressed[r*5 + c] && c_sel[c]) r_out[r] = 1'b1;
        return r_out;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic v);
        bus.ps2_data = v;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // One complete 11-bit frame; bad_parity flips the odd-parity bit.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_parity);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_parity);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_key(input logic [7:0] b);
        applyStimulus(b, 1'b0);
        model_byte(b);
    endtask

    task automatic check_col(input string tag, input logic [4:0] c);
        bus.col = c;
        @(negedge clk);
        checkOutput(tag, {25'd0, bus.row}, {25'd0, expected_row(c)});
    endtask

    initial begin
        int hi_before;
        logic [7:0] b;

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.col      = 5'h1F;
        tb_rst       = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_row", {25'd0, bus.row}, 32'd0);
        checkOutput("reset_out_idle", {31'd0, bus.reset_out}, 32'd0);
        tb_rst = 1'b0;
        repeat (3) @(posedge clk);

        send_key(8'h1C);
        bus.col = 5'b00001;
        @(negedge clk);
        checkOutput("key_a_col0", {25'd0, bus.row}, 32'b0000100);
        bus.col = 5'b00010;
        @(negedge clk);
        checkOutput("key_a_col1", {25'd0, bus.row}, 32'd0);

        send_key(8'hF0);
        send_key(8'h1C);
        bus.col = 5'h1F;
        @(negedge clk);
        checkOutput("break_a", {25'd0, bus.row}, 32'd0);

        send_key(8'h16);
        send_key(8'h1E);
        bus.col = 5'b00110;
        @(negedge clk);
        checkOutput("keys_1_2", {25'd0, bus.row}, 32'b0000001);

        send_key(8'hE0);
        send_key(8'h5A);
        bus.col = 5'b00100;
        @(negedge clk);
        checkOutput("ext_enter", {25'd0, bus.row}, 32'b0001001);
        send_key(8'hE0);
        send_key(8'h75);
        check_col("ext_unmapped", 5'h1F);

        // Abandon a frame after four data bits, then let the receiver time out.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        bus.ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(posedge clk);
        send_key(8'h45);
        bus.col = 5'b00001;
        @(negedge clk);
        checkOutput("after_timeout_bit", {31'd0, bus.row[0]}, 32'd1);
        check_col("after_timeout_all", 5'h1F);

        send_key(8'hF0);
        send_key(8'h16);
        applyStimulus(8'h16, 1'b1);
`ifndef PS2_PARITY_CHECK_EN
        model_byte(8'h16);
`endif
        check_col("bad_parity", 5'b00010);

        for (int n = 0; n < 120; n++) begin
            b = pool[$urandom_range(0, 29)];
            send_key(b);
            check_col($sformatf("rand_%0d_%0h", n, b), 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        tb_rst = 1'b1;
        model_reset();
        bus.col = 5'h1F;
        @(negedge clk);
        checkOutput("mid_reset_row", {25'd0, bus.row}, 32'd0);
        tb_rst = 1'b0;
        repeat (3) @(posedge clk);

        send_key(8'h45);
        send_key(8'h29);
        check_col("pre_f12", 5'h1F);
        hi_before = hi_cnt;
        applyStimulus(8'h07, 1'b0);
        for (int i = 0; i < 8000 && bus.reset_out; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_end", {31'd0, bus.reset_out}, 32'd0);
        checkOutput("reset_pulse_len", hi_cnt - hi_before, RSTLEN);
        model_reset();
        check_col("f12_cleared", 5'h1F);

        hi_before = hi_cnt;
        send_key(8'hF0);
        send_key(8'h07);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("f12_break", hi_cnt - hi_before, 0);

        send_key(8'h66);
        check_col("post_f12_key", 5'h1F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
